pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank.sv | 152 +++++++++++++++
 tb/tb_pwm_bank.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Bank of independent PWM / H-bridge channels behind a four-state request/acknowledge handshake.
// Each channel's new settings are held in shadow registers and applied only when its counter wraps, so pulses never glitch.
module pwm_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CH_W   = 2
) (
  input  logic                     clock,
  input  logic                     clock_valid,
  input  logic                     reset,
  input  logic                     pwm_command,
  output logic                     pwm_response,
  input  logic [CH_W-1:0]          pwm_channel,
  input  logic [WIDTH-1:0]         pwm_period,
  input  logic signed [WIDTH-1:0]  pwm_compare,
  input  logic                     pwm_brake,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH-1:0]        pwm_in1,
  output logic [NUM_CH-1:0]        pwm_in2
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t state_q, state_d;
  logic   resp_q, resp_d;

  // Absolute value of a signed compare; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_f(input logic signed [WIDTH-1:0] c);
    logic [WIDTH-1:0] u;
    u = $unsigned(c);
    return c[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  // Handshake FSM: state register
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        state_q <= ST_RESET;
        resp_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        resp_q  <= resp_d;
      end
    end
  end

  // Acknowledge is held only while the host keeps requesting, so it drops as the FSM leaves RESPONSE.
  always_comb begin
    state_d = state_q;
    resp_d  = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  if (pwm_command) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (pwm_command) resp_d = 1'b1;
        else             state_d = ST_IDLE;
      end
      default:  state_d = ST_RESET;
    endcase
  end

  assign pwm_response = resp_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0]        cnt_q, cnt_d, per_q, per_d, sh_per_q, sh_per_d;
    logic signed [WIDTH-1:0] cmp_q, cmp_d, sh_cmp_q, sh_cmp_d;
    logic                    brk_q, brk_d, sh_brk_q, sh_brk_d, pend_q, pend_d;
    logic                    out_q, out_d, in1_q, in1_d, in2_q, in2_d;
    logic                    wr_sel, wrap;

    // Out-of-range channel indices simply match no channel.
    assign wr_sel = (state_q == ST_WRITE) && (pwm_channel == CH_W'(g));
    assign wrap   = (cnt_q == per_q);

    always_comb begin
      per_d    = per_q;
      cmp_d    = cmp_q;
      brk_d    = brk_q;
      sh_per_d = sh_per_q;
      sh_cmp_d = sh_cmp_q;
      sh_brk_d = sh_brk_q;
      pend_d   = pend_q;
      cnt_d    = wrap ? '0 : cnt_q + WIDTH'(1);
      if (wrap && pend_q) begin
        per_d  = sh_per_q;
        cmp_d  = sh_cmp_q;
        brk_d  = sh_brk_q;
        pend_d = 1'b0;
      end
      // A write landing on the update cycle stays pending for the following wrap.
      if (wr_sel) begin
        sh_per_d = pwm_period;
        sh_cmp_d = pwm_compare;
        sh_brk_d = pwm_brake;
        pend_d   = 1'b1;
      end
      out_d = (cnt_q < mag_f(cmp_q));
      if (cmp_q[WIDTH-1]) begin
        in1_d = 1'b0;
        in2_d = 1'b1;
      end else if (cmp_q == '0) begin
        in1_d = brk_q;
        in2_d = brk_q;
      end else begin
        in1_d = 1'b1;
        in2_d = 1'b0;
      end
    end

    // Channel registers: counter, active, shadow and output stage
    always_ff @(posedge clock) begin
      if (clock_valid) begin
        if (reset) begin
          cnt_q    <= '0;
          per_q    <= '0;
          cmp_q    <= '0;
          brk_q    <= 1'b0;
          sh_per_q <= '0;
          sh_cmp_q <= '0;
          sh_brk_q <= 1'b0;
          pend_q   <= 1'b0;
          out_q    <= 1'b0;
          in1_q    <= 1'b0;
          in2_q    <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          per_q    <= per_d;
          cmp_q    <= cmp_d;
          brk_q    <= brk_d;
          sh_per_q <= sh_per_d;
          sh_cmp_q <= sh_cmp_d;
          sh_brk_q <= sh_brk_d;
          pend_q   <= pend_d;
          out_q    <= out_d;
          in1_q    <= in1_d;
          in2_q    <= in2_d;
        end
      end
    end

    assign pwm_out[g] = out_q;
    assign pwm_in1[g] = in1_q;
    assign pwm_in2[g] = in2_q;
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table of channel writes with duty/direction checks,
// then glitch-free update, out-of-range write, clock_valid freeze and mid-handshake reset sequences.
module tb_pwm_bank;
  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int CW  = 3;

  logic                clock = 1'b0;
  logic                clock_valid, reset, pwm_command, pwm_response, pwm_brake;
  logic [CW-1:0]       pwm_channel;
  logic [W-1:0]        pwm_period;
  logic signed [W-1:0] pwm_compare;
  logic [NCH-1:0]      pwm_out, pwm_in1, pwm_in2;

  pwm_bank #(.NUM_CH(NCH), .WIDTH(W), .CH_W(CW)) dut (
    .clock        (clock),
    .clock_valid  (clock_valid),
    .reset        (reset),
    .pwm_command  (pwm_command),
    .pwm_response (pwm_response),
    .pwm_channel  (pwm_channel),
    .pwm_period   (pwm_period),
    .pwm_compare  (pwm_compare),
    .pwm_brake    (pwm_brake),
    .pwm_out      (pwm_out),
    .pwm_in1      (pwm_in1),
    .pwm_in2      (pwm_in2)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    logic [31:0] per;
    logic [31:0] cmp;
    bit          brk;
    int          hi;
    bit          in1;
    bit          in2;
  } vec_t;

  typedef struct {
    int ch;
    int hi;
    bit in1;
    bit in2;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   sb_run[$];
  int   runs[$];
  int   total = 0;
  int   bad = 0;
  int   per_now[NCH];
  int   hi_now[NCH];
  bit   in1_now[NCH];
  bit   in2_now[NCH];

  // High-pulse length monitor on channel 1
  bit mon_en = 1'b0;
  bit mon_started, mon_prev;
  int mon_run;
  always @(negedge clock) begin
    if (!mon_en) begin
      mon_started <= 1'b0;
      mon_prev    <= pwm_out[1];
    end else begin
      if (pwm_out[1] && !mon_prev) begin
        mon_run     <= 1;
        mon_started <= 1'b1;
      end else if (pwm_out[1]) begin
        mon_run <= mon_run + 1;
      end else if (mon_prev && mon_started) begin
        runs.push_back(mon_run);
      end
      mon_prev <= pwm_out[1];
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input int ch, input logic [31:0] per, input logic [31:0] cmp, input bit brk);
    int lat;
    pwm_channel = CW'(ch);
    pwm_period  = per;
    pwm_compare = cmp;
    pwm_brake   = brk;
    pwm_command = 1'b1;
    lat = 0;
    while (!pwm_response && lat < 20) begin
      tick();
      lat++;
    end
    check("resp_latency", lat, 3);
    pwm_command = 1'b0;
    tick();
    check("resp_drop", pwm_response, 0);
  endtask

  task automatic measure(input int ch, input int len, input int exp_hi, input bit e1, input bit e2);
    int hi;
    hi = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (pwm_out[ch]) hi++;
    end
    check($sformatf("duty_ch%0d", ch), hi, exp_hi);
    check($sformatf("in1_ch%0d", ch), pwm_in1[ch], e1);
    check($sformatf("in2_ch%0d", ch), pwm_in2[ch], e2);
  endtask

  task automatic wait_rise(input int ch, output bit ok);
    bit prev;
    prev = pwm_out[ch];
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (pwm_out[ch] && !prev) ok = 1'b1;
      prev = pwm_out[ch];
    end
  endtask

  initial begin
    exp_t e;
    bit   ok;
    int   hi, zero_bad;

    vecs[0] = '{0, 32'd99, 32'd10,         1'b0, 10,  1'b1, 1'b0};
    vecs[1] = '{2, 32'd9,  32'hFFFF_FFFC,  1'b0, 4,   1'b0, 1'b1};
    vecs[2] = '{1, 32'd99, 32'd120,        1'b0, 100, 1'b1, 1'b0};
    vecs[3] = '{3, 32'd9,  32'd0,          1'b1, 0,   1'b1, 1'b1};
    vecs[4] = '{3, 32'd9,  32'd0,          1'b0, 0,   1'b0, 1'b0};
    vecs[5] = '{1, 32'd7,  32'h8000_0000,  1'b0, 8,   1'b0, 1'b1};
    vecs[6] = '{2, 32'd0,  32'd1,          1'b0, 1,   1'b1, 1'b0};

    clock_valid = 1'b1;
    reset       = 1'b1;
    pwm_command = 1'b0;
    pwm_channel = '0;
    pwm_period  = '0;
    pwm_compare = '0;
    pwm_brake   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      per_now[c] = 0;
      hi_now[c]  = 0;
      in1_now[c] = 1'b0;
      in2_now[c] = 1'b0;
    end

    wait_ticks(2);
    check("rst_response", pwm_response, 0);
    check("rst_out", pwm_out, 0);
    check("rst_in1", pwm_in1, 0);
    check("rst_in2", pwm_in2, 0);
    reset = 1'b0;
    tick();
    check("idle_response", pwm_response, 0);

    for (int i = 0; i < 7; i++) begin
      sb.push_back('{vecs[i].ch, vecs[i].hi, vecs[i].in1, vecs[i].in2});
      do_write(vecs[i].ch, vecs[i].per, vecs[i].cmp, vecs[i].brk);
      wait_ticks(2 * (per_now[vecs[i].ch] + 1) + 2);
      per_now[vecs[i].ch] = int'(vecs[i].per);
      e = sb.pop_front();
      measure(e.ch, per_now[e.ch] + 1, e.hi, e.in1, e.in2);
      hi_now[e.ch]  = e.hi;
      in1_now[e.ch] = e.in1;
      in2_now[e.ch] = e.in2;
    end

    // Out-of-range channel: handshake completes, nothing changes
    do_write(5, 32'd99, 32'd77, 1'b1);
    wait_ticks(4);
    for (int c = 0; c < NCH; c++) measure(c, per_now[c] + 1, hi_now[c], in1_now[c], in2_now[c]);

    // Compare change mid-pulse on ch1 takes effect only at the wrap
    do_write(1, 32'd99, 32'd50, 1'b0);
    wait_ticks(2 * (per_now[1] + 1) + 2);
    per_now[1] = 99;
    runs.delete();
    mon_en = 1'b1;
    wait_rise(1, ok);
    check("runt_sync", ok, 1);
    wait_ticks(19);
    sb_run.push_back(50);
    sb_run.push_back(80);
    sb_run.push_back(80);
    do_write(1, 32'd99, 32'd80, 1'b0);
    wait_ticks(300);
    mon_en = 1'b0;
    while (sb_run.size() > 0) begin
      int exp_len;
      exp_len = sb_run.pop_front();
      if (runs.size() == 0) check("runt_missing", -1, exp_len);
      else                  check("runt_pulse", runs.pop_front(), exp_len);
    end

    // clock_valid low freezes everything, including reset
    wait_rise(0, ok);
    check("freeze_sync", ok, 1);
    hi = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pwm_out[0]) hi++;
    end
    clock_valid = 1'b0;
    reset       = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (pwm_out[0]) hi++;
      check("freeze_in1", pwm_in1, 4'b0111);
      check("freeze_out2", pwm_out[2], 1);
    end
    reset       = 1'b0;
    clock_valid = 1'b1;
    for (int i = 0; i < 50 && pwm_out[0]; i++) begin
      tick();
      if (pwm_out[0]) hi++;
    end
    check("freeze_pulse_len", hi, 17);

    // Reset in RESPONSE discards the pending write
    pwm_channel = 3'd0;
    pwm_period  = 32'd3;
    pwm_compare = 32'd2;
    pwm_brake   = 1'b0;
    pwm_command = 1'b1;
    for (int i = 0; i < 20 && !pwm_response; i++) tick();
    check("rstmid_resp_seen", pwm_response, 1);
    reset = 1'b1;
    tick();
    check("rstmid_response", pwm_response, 0);
    check("rstmid_out", pwm_out, 0);
    check("rstmid_in1", pwm_in1, 0);
    check("rstmid_in2", pwm_in2, 0);
    pwm_command = 1'b0;
    tick();
    reset = 1'b0;
    zero_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pwm_out != 0 || pwm_in1 != 0 || pwm_in2 != 0 || pwm_response) zero_bad++;
    end
    check("rstmid_discarded", zero_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
